pipe_stage_buf: RTL

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

---
 rtl/pipe_stage_buf.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Two-entry pipeline stage buffer (HEAD + SKID) with valid/ready handshake,
// global enable, flush and a sticky halt flag. State updates on the falling edge.
module pipe_stage_buf #(
  parameter int unsigned NB_DATA  = 32,
  parameter int unsigned NB_CTRL  = 9,
  parameter int unsigned NB_REGWR = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en_pipeline,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [NB_DATA-1:0]  in_data_i,
  input  logic [NB_REGWR-1:0] in_reg_i,
  input  logic [NB_CTRL-1:0]  in_ctrl_i,
  input  logic                in_halt_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [NB_DATA-1:0]  out_data_o,
  output logic [NB_REGWR-1:0] out_reg_o,
  output logic [NB_CTRL-1:0]  out_ctrl_o,
  output logic                out_halt_o,
  output logic [1:0]          count_o,
  output logic                halted_o
);

  typedef struct packed {
    logic [NB_DATA-1:0]  data;
    logic [NB_REGWR-1:0] regwr;
    logic [NB_CTRL-1:0]  ctrl;
    logic                halt;
  } beat_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  beat_t  head_q, head_d;
  beat_t  skid_q, skid_d;
  logic   halted_q, halted_d;

  beat_t  in_beat;
  logic   head_vld, skid_vld, in_ready;
  logic   do_accept, do_release;
  logic   ld_head_in, ld_head_skid, ld_skid_in;

  assign in_beat = {in_data_i, in_reg_i, in_ctrl_i, in_halt_i};

  // State register: occupancy of the two entries
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Next-state: flush empties the stage regardless of enable
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: if (do_accept) state_d = S_ONE;
        S_ONE: begin
          if (do_accept && !do_release)      state_d = S_FULL;
          else if (!do_accept && do_release) state_d = S_EMPTY;
        end
        S_FULL:  if (do_release) state_d = S_ONE;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // Handshake and entry-load controls decoded from registered state only
  always_comb begin
    head_vld     = (state_q != S_EMPTY);
    skid_vld     = (state_q == S_FULL);
    in_ready     = !skid_vld && !halted_q;
    do_accept    = in_valid_i && in_ready && en_pipeline;
    do_release   = head_vld && out_ready_i && en_pipeline;
    ld_head_in   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid_in   = 1'b0;
    if (!flush_i) begin
      case (state_q)
        S_EMPTY: ld_head_in   = do_accept;
        S_ONE: begin
          ld_head_in = do_accept && do_release;
          ld_skid_in = do_accept && !do_release;
        end
        S_FULL:  ld_head_skid = do_release;
        default: ;
      endcase
    end
  end

  // Payload next values; a release still updates the halt flag during flush
  always_comb begin
    head_d   = head_q;
    skid_d   = skid_q;
    halted_d = halted_q | (do_release & head_q.halt);
    if (ld_head_in)   head_d = in_beat;
    if (ld_head_skid) head_d = skid_q;
    if (ld_skid_in)   skid_d = in_beat;
  end

  // Payload and halt-flag registers
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      head_q   <= '0;
      skid_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      head_q   <= head_d;
      skid_q   <= skid_d;
      halted_q <= halted_d;
    end
  end

  // Outputs come straight from HEAD; bubbles carry no ctrl/halt side effects
  assign in_ready_o  = in_ready;
  assign out_valid_o = head_vld;
  assign out_data_o  = head_q.data;
  assign out_reg_o   = head_q.regwr;
  assign out_ctrl_o  = head_vld ? head_q.ctrl : '0;
  assign out_halt_o  = head_vld & head_q.halt;
  assign count_o     = 2'(head_vld) + 2'(skid_vld);
  assign halted_o    = halted_q;

endmodule
